fifo_ptr_ctrl: RTL

Pointer and flag controller that turns the 8x4 dual-port Memory into a synchronous FIFO.
- Sits directly upstream of Memory's dual-port side: drives its write enable, write address, read address and write data.
- Consumes Memory's dual-port read data, which is an asynchronous read of the entry at the read address.
- Provides full/empty/count status and a registered pop-data output to the downstream consumer.

---
 rtl/fifo_ptr_ctrl_if.sv | 36 +++
 rtl/fifo_ptr_ctrl.sv | 78 +++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl_if.sv
// Bundle for the FIFO controller: producer/consumer handshake, status and Memory dual-port side.
interface fifo_ptr_ctrl_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
);
    logic              flush;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr_wr;
    logic [ADDR_W-1:0] mem_addr_rd;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Environment side: drives requests and returns Memory read data.
    modport master (
        output flush, push, push_data, pop, mem_dout,
        input  pop_data, pop_valid, full, empty, count, overflow, underflow,
               mem_we, mem_addr_wr, mem_addr_rd, mem_din
    );

    // Controller side.
    modport slave (
        input  flush, push, push_data, pop, mem_dout,
        output pop_data, pop_valid, full, empty, count, overflow, underflow,
               mem_we, mem_addr_wr, mem_addr_rd, mem_din
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller turning the 8x4 dual-port Memory into a synchronous FIFO.
// Wrap-bit pointers give full/empty/count directly; pop data is registered from the async read port.
module fifo_ptr_ctrl #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
) (
    input logic           clk,
    input logic           reset_n,
    fifo_ptr_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] pop_data_q;
    logic              pop_valid_q;
    logic              overflow_q;
    logic              underflow_q;

    logic full_c;
    logic empty_c;
    logic push_acc_c;
    logic pop_acc_c;

    // Status decoded straight from the pointers.
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // Flush wins over both requests, so nothing is written or read in a flush cycle.
    assign push_acc_c = bus.push & ~full_c  & ~bus.flush;
    assign pop_acc_c  = bus.pop  & ~empty_c & ~bus.flush;

    assign bus.empty       = empty_c;
    assign bus.full        = full_c;
    assign bus.count       = wr_ptr - rd_ptr;
    assign bus.mem_we      = push_acc_c;
    assign bus.mem_addr_wr = wr_ptr[ADDR_W-1:0];
    assign bus.mem_addr_rd = rd_ptr[ADDR_W-1:0];
    assign bus.mem_din     = bus.push_data;
    assign bus.pop_data    = pop_data_q;
    assign bus.pop_valid   = pop_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

    // Pointer, pop-data and sticky error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_acc_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_acc_c) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                pop_data_q <= bus.mem_dout;
            end
            pop_valid_q <= pop_acc_c;
            if (bus.push && full_c) begin
                overflow_q <= 1'b1;
            end
            if (bus.pop && empty_c) begin
                underflow_q <= 1'b1;
            end
        end
    end
endmodule
